aligned_word_buffer: RTL and testbench

- Downstream stage of the byte-packing aligner. Accepts its 256-bit packed words into a small FIFO and throttles the aligner through its write-enable.
- Emits words on a valid/ready output stream to the memory writer.
- On end-of-stream flush, drains the FIFO, then emits the aligner's residual partial word as a final beat tagged with last and a valid-byte count.

---
 rtl/aligned_word_buffer_pkg.sv | 14 +
 rtl/aligned_word_buffer_word_fifo.sv | 57 +++++
 rtl/aligned_word_buffer.sv | 142 ++++++++++++++
 tb/tb_aligned_word_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/aligned_word_buffer_pkg.sv
// Shared constants and state encoding for the aligned word buffer and its byte-packing aligner.
package aligned_word_buffer_pkg;

    localparam int unsigned WORD_BYTES  = 32;
    localparam int unsigned LEN_WIDTH   = 9;
    localparam int unsigned BYTES_WIDTH = 6;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StTail  = 2'd2
    } state_e;

endpackage

// File: rtl/aligned_word_buffer_word_fifo.sv
// First-word-fall-through word FIFO; head entry is visible on rd_data whenever empty=0.
module aligned_word_buffer_word_fifo #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/aligned_word_buffer.sv
// Buffers aligner words and appends the flushed residual as a tagged last beat.
// Optional statistics outputs are enabled by defining ALIGNED_WORD_BUFFER_STATS_EN.
module aligned_word_buffer
    import aligned_word_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = WORD_BYTES * 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PTR_WIDTH   = 2,
    parameter int unsigned LEN_WIDTH   = aligned_word_buffer_pkg::LEN_WIDTH,
    parameter int unsigned BYTES_WIDTH = aligned_word_buffer_pkg::BYTES_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    up_wrt_en,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   flush_data,
    input  logic [LEN_WIDTH-1:0]    flush_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [BYTES_WIDTH-1:0]  out_bytes
`ifdef ALIGNED_WORD_BUFFER_STATS_EN
    ,
    output logic [31:0]             total_bytes,
    output logic                    overflow_err
`endif
);

    localparam int unsigned CntW      = PTR_WIDTH + 1;
    localparam int unsigned WordBytes = DATA_WIDTH / 8;

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  tail_data_q;
    logic [BYTES_WIDTH-1:0] tail_bytes_q;

    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntW-1:0]       count_next;

    function automatic logic [DATA_WIDTH-1:0] mask_residual(input logic [DATA_WIDTH-1:0] data,
                                                            input logic [LEN_WIDTH-1:0]  len);
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (i < int'(len)) begin
                res[i] = data[i];
            end
        end
        return res;
    endfunction

    assign up_wrt_en  = (state_q == StRun) && !fifo_full;
    assign fifo_wr    = in_valid && up_wrt_en;
    assign fifo_rd    = (state_q != StTail) && !fifo_empty && out_ready;
    assign count_next = fifo_count + CntW'(fifo_wr) - CntW'(fifo_rd);

    aligned_word_buffer_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Tail is entered as soon as the FIFO will be empty, so an empty flush emits next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            tail_data_q  <= '0;
            tail_bytes_q <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (flush) begin
                        tail_data_q  <= mask_residual(flush_data, flush_len);
                        tail_bytes_q <= BYTES_WIDTH'(flush_len >> 3);
                        state_q      <= (count_next == '0) ? StTail : StDrain;
                    end
                end
                StDrain: begin
                    if (count_next == '0) begin
                        state_q <= StTail;
                    end
                end
                StTail: begin
                    if (out_ready) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_bytes = '0;
        if (state_q == StTail) begin
            out_valid = 1'b1;
            out_data  = tail_data_q;
            out_last  = 1'b1;
            out_bytes = tail_bytes_q;
        end else if (!fifo_empty) begin
            out_valid = 1'b1;
            out_data  = fifo_rd_data;
            out_bytes = BYTES_WIDTH'(WordBytes);
        end
    end

`ifdef ALIGNED_WORD_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_bytes  <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                total_bytes <= total_bytes + 32'(out_bytes);
            end
            if (in_valid && (state_q == StRun) && fifo_full) begin
                overflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aligned_word_buffer.sv
// Directed self-checking bench for aligned_word_buffer.
module tb_aligned_word_buffer;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [255:0] in_data;
    logic         up_wrt_en;
    logic         flush;
    logic [255:0] flush_data;
    logic [8:0]   flush_len;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         out_last;
    logic [5:0]   out_bytes;
`ifdef ALIGNED_WORD_BUFFER_STATS_EN
    logic [31:0]  total_bytes;
    logic         overflow_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] w [8];
    logic [255:0] exp_tail;

    aligned_word_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .up_wrt_en  (up_wrt_en),
        .flush      (flush),
        .flush_data (flush_data),
        .flush_len  (flush_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_bytes  (out_bytes)
`ifdef ALIGNED_WORD_BUFFER_STATS_EN
        ,
        .total_bytes  (total_bytes),
        .overflow_err (overflow_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [255:0] data, input logic last,
                              input logic [5:0] bytes);
        check({tag, ".valid"}, 256'(out_valid), 256'd1);
        check({tag, ".data"},  out_data, data);
        check({tag, ".last"},  256'(out_last), 256'(last));
        check({tag, ".bytes"}, 256'(out_bytes), 256'(bytes));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            w[i] = {8{32'h1000_0000 + 32'(i * 32'h0101_0101)}};
        end
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        flush_data = '0;
        flush_len  = '0;
        out_ready  = 1'b1;

        // Reset then idle, with mid-cycle asynchronous release
        repeat (2) @(posedge clk);
        #3;
        check("rst.wrt_en", 256'(up_wrt_en), 256'd1);
        check("rst.valid",  256'(out_valid), 256'd0);
        check("rst.data",   out_data, 256'd0);
        check("rst.last",   256'(out_last), 256'd0);
        check("rst.bytes",  256'(out_bytes), 256'd0);
        reset = 1'b1;
        step();
        step();
        check("idle.valid",  256'(out_valid), 256'd0);
        check("idle.data",   out_data, 256'd0);
        check("idle.wrt_en", 256'(up_wrt_en), 256'd1);

        // Streaming with out_ready=1: each word one cycle after acceptance
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            step();
            check_beat($sformatf("stream%0d", i), w[i], 1'b0, 6'd32);
            check($sformatf("stream%0d.wrt_en", i), 256'(up_wrt_en), 256'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream.drained", 256'(out_valid), 256'd0);

        // Backpressure: four words fill the FIFO, fifth is held off
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            step();
            check($sformatf("bp.fill%0d.wrt_en", i), 256'(up_wrt_en), 256'(i < 3));
        end
        in_data = w[4];
        step();
        check("bp.full.wrt_en", 256'(up_wrt_en), 256'd0);
        check_beat("bp.hold", w[0], 1'b0, 6'd32);
        out_ready = 1'b1;
        step();
        check("bp.reopen.wrt_en", 256'(up_wrt_en), 256'd1);
        check_beat("bp.out1", w[1], 1'b0, 6'd32);
        step();
        in_valid = 1'b0;
        check_beat("bp.out2", w[2], 1'b0, 6'd32);
        step();
        check_beat("bp.out3", w[3], 1'b0, 6'd32);
        step();
        check_beat("bp.out4", w[4], 1'b0, 6'd32);
        step();
        check("bp.empty", 256'(out_valid), 256'd0);

        // Flush with two words queued, 40-bit residual of all ones
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = w[5];
        step();
        in_data = w[6];
        step();
        in_valid   = 1'b0;
        flush      = 1'b1;
        flush_data = '1;
        flush_len  = 9'd40;
        step();
        flush      = 1'b0;
        flush_data = '0;
        check("fl.drain.wrt_en", 256'(up_wrt_en), 256'd0);
        check_beat("fl.w5", w[5], 1'b0, 6'd32);
        out_ready = 1'b1;
        step();
        check_beat("fl.w6", w[6], 1'b0, 6'd32);
        check("fl.w6.wrt_en", 256'(up_wrt_en), 256'd0);
        out_ready = 1'b0;
        step();
        check_beat("fl.w6.hold", w[6], 1'b0, 6'd32);
        out_ready = 1'b1;
        step();
        exp_tail = 256'h00FF_FFFF_FFFF;
        check_beat("fl.tail", exp_tail, 1'b1, 6'd5);
        check("fl.tail.wrt_en", 256'(up_wrt_en), 256'd0);
        out_ready = 1'b0;
        step();
        check_beat("fl.tail.hold", exp_tail, 1'b1, 6'd5);
        out_ready = 1'b1;
        step();
        check("fl.done.valid",  256'(out_valid), 256'd0);
        check("fl.done.wrt_en", 256'(up_wrt_en), 256'd1);

        // Zero-length flush on an empty FIFO
        flush      = 1'b1;
        flush_data = '1;
        flush_len  = 9'd0;
        step();
        flush      = 1'b0;
        flush_data = '0;
        check_beat("z.tail", 256'd0, 1'b1, 6'd0);
        step();
        check("z.done.valid", 256'(out_valid), 256'd0);

        // Flush coincident with a word: word precedes the tail; low 3 length bits ignored
        in_valid   = 1'b1;
        in_data    = w[7];
        flush      = 1'b1;
        flush_data = 256'hDEAD_BEEF;
        flush_len  = 9'd16;
        step();
        in_valid   = 1'b0;
        flush      = 1'b0;
        flush_data = '0;
        check_beat("co.word", w[7], 1'b0, 6'd32);
        step();
        check_beat("co.tail", 256'h0000_BEEF, 1'b1, 6'd2);
`ifdef ALIGNED_WORD_BUFFER_STATS_EN
        // 3 + 5 + 2 + 1 full words, plus 5- and 0-byte tails
        check("stats.total", 256'(total_bytes), 256'd357);
        check("stats.ovf",   256'(overflow_err), 256'd1);
`endif
        out_ready = 1'b0;
        step();
        check_beat("co.tail.hold", 256'h0000_BEEF, 1'b1, 6'd2);

        // Asynchronous reset while in TAIL
        #2;
        reset = 1'b0;
        #1;
        check("rt.valid",  256'(out_valid), 256'd0);
        check("rt.wrt_en", 256'(up_wrt_en), 256'd1);
        check("rt.data",   out_data, 256'd0);
`ifdef ALIGNED_WORD_BUFFER_STATS_EN
        check("rt.total", 256'(total_bytes), 256'd0);
        check("rt.ovf",   256'(overflow_err), 256'd0);
`endif
        #3;
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("rt.after.valid",  256'(out_valid), 256'd0);
        check("rt.after.wrt_en", 256'(up_wrt_en), 256'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
